// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS/CTRL bit
// indices, gap counter width and the TX sequencer state encoding.
package uart_mmio_bridge_pkg;

    localparam logic [3:0] UART_DATA_OFS = 4'h0;
    localparam logic [3:0] UART_STAT_OFS = 4'h4;
    localparam logic [3:0] UART_CTRL_OFS = 4'h8;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_TX_BUSY  = 5;
    localparam int ST_TX_OVF   = 6;

    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;
    localparam int CTRL_LB   = 2;
    localparam int CTRL_CLR  = 4;

    localparam int GAP_W = 20;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. Pushes while full are dropped unless a pop
// happens in the same cycle, in which case both take effect.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is not reset; a flush only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU bus bridge to a UART byte interface: TX/RX FIFOs, paced TX sequencer, RX edge
// capture, DATA/STATUS/CTRL registers and irq. Optional loopback: UART_BRIDGE_LOOPBACK_EN.
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int FIFO_AW  = 4,
    parameter int GAP_BITS = 11
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        uart_send_en,
    output logic [7:0]  uart_din,
    input  logic        uart_done,
    input  logic [7:0]  uart_data
);

    localparam int BPS_CNT    = CLK_FREQ / UART_BPS;
    localparam int GAP_CYCLES = GAP_BITS * BPS_CNT;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_pop;
    logic             tx_busy;

    logic       tx_push, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_din, rx_dout;

    logic        done_q;
    logic        rx_edge;
    logic        rx_irq_en, tx_irq_en;
    logic        rx_ovr, tx_ovf;
    logic        wr_data, wr_ctrl, rd_data;
    logic [31:0] status;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;

    assign wr_data = bus_ce & bus_we  & (bus_addr == UART_DATA_OFS);
    assign wr_ctrl = bus_ce & bus_we  & (bus_addr == UART_CTRL_OFS);
    assign rd_data = bus_ce & ~bus_we & (bus_addr == UART_DATA_OFS);

    assign tx_push = wr_data;
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_edge = uart_done & ~done_q;
    assign tx_busy = (state != TX_IDLE);

`ifdef UART_BRIDGE_LOOPBACK_EN
    logic lb_en;
    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[31:5], bus_wdata[3]};
    // In loopback the sent byte replaces the UART receive path entirely.
    assign rx_push = lb_en ? (state == TX_SEND) : rx_edge;
    assign rx_din  = lb_en ? uart_din : uart_data;
    assign ctrl_rd = {29'b0, lb_en, tx_irq_en, rx_irq_en};
`else
    logic unused_wdata;
    assign unused_wdata = ^{bus_wdata[31:5], bus_wdata[3:2]};
    assign rx_push = rx_edge;
    assign rx_din  = uart_data;
    assign ctrl_rd = {30'b0, tx_irq_en, rx_irq_en};
`endif

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (bus_wdata[7:0]),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_din),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= TX_IDLE;
            gap_cnt  <= '0;
            uart_din <= '0;
        end else begin
            state <= state_next;
            if (tx_pop) uart_din <= tx_dout;
            if (state == TX_SEND) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == TX_WAIT && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        tx_pop       = 1'b0;
        uart_send_en = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                uart_send_en = 1'b1;
                state_next   = TX_WAIT;
            end
            TX_WAIT: begin
                if (gap_cnt == '0) state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            UART_DATA_OFS: if (!rx_empty) rd_mux = {23'b0, 1'b1, rx_dout};
            UART_STAT_OFS: rd_mux = status;
            UART_CTRL_OFS: rd_mux = ctrl_rd;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done_q    <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            rx_ovr    <= 1'b0;
            tx_ovf    <= 1'b0;
            bus_rdata <= '0;
            irq       <= 1'b0;
`ifdef UART_BRIDGE_LOOPBACK_EN
            lb_en     <= 1'b0;
`endif
        end else begin
            done_q <= uart_done;
            if (wr_ctrl) begin
                rx_irq_en <= bus_wdata[CTRL_RXIE];
                tx_irq_en <= bus_wdata[CTRL_TXIE];
`ifdef UART_BRIDGE_LOOPBACK_EN
                lb_en     <= bus_wdata[CTRL_LB];
`endif
                if (bus_wdata[CTRL_CLR]) begin
                    rx_ovr <= 1'b0;
                    tx_ovf <= 1'b0;
                end
            end
            // A same-cycle pop frees a slot, so only a genuinely dropped byte is flagged.
            if (rx_push & rx_full & ~rx_pop) rx_ovr <= 1'b1;
            if (tx_push & tx_full & ~tx_pop) tx_ovf <= 1'b1;
            if (bus_ce & ~bus_we) bus_rdata <= rd_mux;
            irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy)
                 | rx_ovr | tx_ovf;
        end
    end

endmodule
